// File: rtl/pc_update_unit.sv
// Program-counter register stage with EPC and a hardware exception sequencer that
// fetches the handler address byte from memory and loads it into the PC.
module pc_update_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] VEC_OPCODE  = 32'd253,
    parameter logic [31:0] VEC_OVF     = 32'd254,
    parameter logic [31:0] VEC_DIV0    = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        pc_write_cond_ne,
    input  logic        zero,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [31:0] vec_mem_data,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] vec_mem_addr,
    output logic        vec_mem_rd,
    output logic        exc_busy,
    output logic [1:0]  exc_cause,
    output logic        exc_done
);

    typedef enum logic [1:0] {StIdle, StExcAddr, StExcWait, StExcLoad} state_e;

    localparam logic [2:0] CntInit = 3'(MEM_LATENCY - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] vec_addr_q, vec_addr_d;
    logic [1:0]  cause_q, cause_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        exc_req;
    logic        pc_we;

    // Only the low byte of the memory word carries the handler address.
    logic unused_data;
    assign unused_data = ^vec_mem_data[31:8];

    assign exc_req = exc_opcode | exc_ovf | exc_div0;
    assign pc_we   = pc_write | (pc_write_cond & zero) | (pc_write_cond_ne & ~zero);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        vec_addr_d = vec_addr_q;
        cause_d    = cause_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (exc_req) begin
                    epc_d   = pc_q - 32'd4;
                    state_d = StExcAddr;
                    if (exc_opcode) begin
                        cause_d    = 2'b01;
                        vec_addr_d = VEC_OPCODE;
                    end else if (exc_ovf) begin
                        cause_d    = 2'b10;
                        vec_addr_d = VEC_OVF;
                    end else begin
                        cause_d    = 2'b11;
                        vec_addr_d = VEC_DIV0;
                    end
                end else if (pc_we) begin
                    pc_d = pc_next;
                end
            end
            StExcAddr: begin
                cnt_d   = CntInit;
                state_d = StExcWait;
            end
            StExcWait: begin
                // Leave when the counter is already 0 or this decrement brings it to 0.
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = StExcLoad;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StExcLoad: begin
                pc_d    = {24'd0, vec_mem_data[7:0]};
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            epc_q      <= 32'd0;
            vec_addr_q <= 32'd0;
            cause_q    <= 2'b00;
            cnt_q      <= 3'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            vec_addr_q <= vec_addr_d;
            cause_q    <= cause_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign epc          = epc_q;
    assign vec_mem_addr = vec_addr_q;
    assign exc_cause    = cause_q;
    assign vec_mem_rd   = (state_q == StExcAddr);
    assign exc_busy     = (state_q != StIdle);
    assign exc_done     = (state_q == StExcLoad);

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit; a second instance built with
// MEM_LATENCY=3 shares the stimulus and is checked for the longer wait phase.
module tb_pc_update_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_next;
    logic        pc_write, pc_write_cond, pc_write_cond_ne, zero;
    logic        exc_opcode, exc_ovf, exc_div0;
    logic [31:0] vec_mem_data;

    logic [31:0] pc, epc, vec_mem_addr;
    logic        vec_mem_rd, exc_busy, exc_done;
    logic [1:0]  exc_cause;

    logic [31:0] pc_l3, epc_l3, vaddr_l3;
    logic        vrd_l3, busy_l3, done_l3;
    logic [1:0]  cause_l3;

    int n_tests = 0;
    int n_fail  = 0;

    // {pc_write, pc_write_cond, pc_write_cond_ne, zero}, pc_next, expected pc
    localparam logic [3:0]  WR_CTRL [7] = '{4'b1000, 4'b0101, 4'b0100, 4'b0010,
                                            4'b0011, 4'b0001, 4'b1001};
    localparam logic [31:0] WR_NEXT [7] = '{32'h14, 32'h80, 32'h90, 32'hA0,
                                            32'hB0, 32'hC0, 32'hD0};
    localparam logic [31:0] WR_EXP  [7] = '{32'h14, 32'h80, 32'h80, 32'hA0,
                                            32'hA0, 32'hA0, 32'hD0};

    always #5 clk = ~clk;

    pc_update_unit #(.MEM_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne), .zero(zero),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .vec_mem_data(vec_mem_data), .pc(pc), .epc(epc), .vec_mem_addr(vec_mem_addr),
        .vec_mem_rd(vec_mem_rd), .exc_busy(exc_busy), .exc_cause(exc_cause),
        .exc_done(exc_done)
    );

    pc_update_unit #(.MEM_LATENCY(3)) dut_l3 (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .pc_write_cond_ne(pc_write_cond_ne), .zero(zero),
        .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .vec_mem_data(vec_mem_data), .pc(pc_l3), .epc(epc_l3), .vec_mem_addr(vaddr_l3),
        .vec_mem_rd(vrd_l3), .exc_busy(busy_l3), .exc_cause(cause_l3),
        .exc_done(done_l3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_next = '0; pc_write = 0; pc_write_cond = 0; pc_write_cond_ne = 0; zero = 0;
        exc_opcode = 0; exc_ovf = 0; exc_div0 = 0; vec_mem_data = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_pc(input logic [31:0] v);
        pc_next = v; pc_write = 1'b1;
        tick();
        pc_write = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        load_pc(32'h40);
        vec_mem_data = 32'h40;
        exc_ovf = 1'b1;
        tick();
        exc_ovf = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (epc !== 32'h3C) begin n_fail++; $display("FAIL pre_reset_epc: got %h want %h", epc, 32'h3C); end
        do_reset();
        n_tests++;
        if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        n_tests++;
        if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h want %h", epc, 32'h0); end
        n_tests++;
        if (exc_busy !== 1'b0 || exc_done !== 1'b0 || vec_mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got busy=%b done=%b rd=%b want 0 0 0",
                               exc_busy, exc_done, vec_mem_rd);
        end
        n_tests++;
        if (exc_cause !== 2'b00 || vec_mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_cause_addr: got %b/%h want 00/0", exc_cause, vec_mem_addr);
        end
    endtask

    task automatic test_write_paths();
        do_reset();
        load_pc(32'h10);
        n_tests++;
        if (pc !== 32'h10) begin n_fail++; $display("FAIL write_init: got %h want %h", pc, 32'h10); end
        for (int i = 0; i < 7; i++) begin
            {pc_write, pc_write_cond, pc_write_cond_ne, zero} = WR_CTRL[i];
            pc_next = WR_NEXT[i];
            #1;
            if (i == 0) begin
                n_tests++;
                if (pc !== 32'h10) begin n_fail++; $display("FAIL write_no_comb: got %h want %h", pc, 32'h10); end
            end
            tick();
            n_tests++;
            if (pc !== WR_EXP[i]) begin
                n_fail++; $display("FAIL write_vec%0d: got %h want %h", i, pc, WR_EXP[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_exception_ovf();
        do_reset();
        load_pc(32'h24);
        vec_mem_data = 32'h0000_00A7;
        exc_ovf = 1'b1; pc_write = 1'b1; pc_next = 32'h99;
        tick();
        exc_ovf = 1'b0; pc_write = 1'b0;
        n_tests++;
        if (pc !== 32'h24) begin n_fail++; $display("FAIL ovf_entry_pc: got %h want %h", pc, 32'h24); end
        n_tests++;
        if (epc !== 32'h20) begin n_fail++; $display("FAIL ovf_epc: got %h want %h", epc, 32'h20); end
        n_tests++;
        if (exc_cause !== 2'b10) begin n_fail++; $display("FAIL ovf_cause: got %b want 10", exc_cause); end
        n_tests++;
        if (vec_mem_rd !== 1'b1 || vec_mem_addr !== 32'd254 || exc_busy !== 1'b1 || exc_done !== 1'b0) begin
            n_fail++; $display("FAIL ovf_addr_phase: got rd=%b addr=%0d busy=%b done=%b want 1 254 1 0",
                               vec_mem_rd, vec_mem_addr, exc_busy, exc_done);
        end
        tick();
        n_tests++;
        if (vec_mem_rd !== 1'b0 || vec_mem_addr !== 32'd254 || exc_done !== 1'b0 || exc_busy !== 1'b1) begin
            n_fail++; $display("FAIL ovf_wait_phase: got rd=%b addr=%0d done=%b busy=%b want 0 254 0 1",
                               vec_mem_rd, vec_mem_addr, exc_done, exc_busy);
        end
        tick();
        n_tests++;
        if (exc_done !== 1'b1 || pc !== 32'h24) begin
            n_fail++; $display("FAIL ovf_load_phase: got done=%b pc=%h want 1 %h", exc_done, pc, 32'h24);
        end
        tick();
        n_tests++;
        if (pc !== 32'hA7 || exc_busy !== 1'b0 || exc_done !== 1'b0 || exc_cause !== 2'b10) begin
            n_fail++; $display("FAIL ovf_return: got pc=%h busy=%b done=%b cause=%b want a7 0 0 10",
                               pc, exc_busy, exc_done, exc_cause);
        end
        repeat (4) tick();
    endtask

    task automatic test_priority_and_busy();
        do_reset();
        load_pc(32'h100);
        vec_mem_data = 32'hFFFF_FF12;
        exc_opcode = 1'b1; exc_div0 = 1'b1;
        tick();
        exc_opcode = 1'b0;
        n_tests++;
        if (exc_cause !== 2'b01 || vec_mem_addr !== 32'd253 || epc !== 32'hFC) begin
            n_fail++; $display("FAIL prio_entry: got cause=%b addr=%0d epc=%h want 01 253 fc",
                               exc_cause, vec_mem_addr, epc);
        end
        // exc_div0 stays high through the whole busy window
        repeat (3) tick();
        exc_div0 = 1'b0;
        n_tests++;
        if (pc !== 32'h12 || exc_busy !== 1'b0) begin
            n_fail++; $display("FAIL byte_load: got pc=%h busy=%b want 12 0", pc, exc_busy);
        end
        tick();
        n_tests++;
        if (exc_busy !== 1'b0 || pc !== 32'h12 || exc_cause !== 2'b01 || epc !== 32'hFC) begin
            n_fail++; $display("FAIL busy_ignore: got busy=%b pc=%h cause=%b epc=%h want 0 12 01 fc",
                               exc_busy, pc, exc_cause, epc);
        end
        repeat (4) tick();
    endtask

    task automatic test_mem_latency3();
        int waits = 0;
        int load_edge = -1;
        do_reset();
        load_pc(32'h200);
        vec_mem_data = 32'h55;
        exc_ovf = 1'b1;
        tick();
        exc_ovf = 1'b0;
        n_tests++;
        if (vrd_l3 !== 1'b1 || vaddr_l3 !== 32'd254) begin
            n_fail++; $display("FAIL l3_addr: got rd=%b addr=%0d want 1 254", vrd_l3, vaddr_l3);
        end
        // Edges counted after the entry edge; the entry edge itself is the first of five.
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (busy_l3 && !vrd_l3 && !done_l3) waits++;
            if (pc_l3 === 32'h55 && load_edge < 0) load_edge = e;
        end
        n_tests++;
        if (waits != 2) begin n_fail++; $display("FAIL l3_wait_cycles: got %0d want 2", waits); end
        n_tests++;
        if (load_edge != 4) begin n_fail++; $display("FAIL l3_load_edge: got %0d want 4", load_edge); end
    endtask

    task automatic test_epc_wrap();
        do_reset();
        exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        n_tests++;
        if (epc !== 32'hFFFF_FFFC || exc_cause !== 2'b11 || vec_mem_addr !== 32'd255) begin
            n_fail++; $display("FAIL epc_wrap: got epc=%h cause=%b addr=%0d want fffffffc 11 255",
                               epc, exc_cause, vec_mem_addr);
        end
        repeat (6) tick();
    endtask

    task automatic test_reset_mid_sequence();
        int dones = 0;
        do_reset();
        load_pc(32'h300);
        vec_mem_data = 32'h77;
        exc_opcode = 1'b1;
        tick();
        exc_opcode = 1'b0;
        tick();
        n_tests++;
        if (exc_busy !== 1'b1 || vec_mem_rd !== 1'b0) begin
            n_fail++; $display("FAIL mid_in_wait: got busy=%b rd=%b want 1 0", exc_busy, vec_mem_rd);
        end
        do_reset();
        n_tests++;
        if (pc !== 32'h0 || exc_busy !== 1'b0 || exc_done !== 1'b0 || epc !== 32'h0 || exc_cause !== 2'b00) begin
            n_fail++; $display("FAIL mid_reset: got pc=%h busy=%b done=%b epc=%h cause=%b want 0 0 0 0 00",
                               pc, exc_busy, exc_done, epc, exc_cause);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (exc_done || done_l3 || busy_l3) dones++;
        end
        n_tests++;
        if (dones != 0 || pc !== 32'h0) begin
            n_fail++; $display("FAIL mid_abort: got activity=%0d pc=%h want 0 0", dones, pc);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_write_paths();
        test_exception_ovf();
        test_priority_and_busy();
        test_mem_latency3();
        test_epc_wrap();
        test_reset_mid_sequence();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
